bus_xfer_ctrl: RTL and testbench

Sequencer that drives the shared tri-state datapath bus by generating the per-register output-enable and input-enable strobes. It accepts one transfer request at a time, either register-to-register or immediate-to-register, and schedules a drive phase and a latch phase before acknowledging. It sits between the control unit and the register file; each register's output_enable/input_enable pins connect to one bit of this block's one-hot outputs.

---
 rtl/bus_xfer_ctrl.sv | 172 +++++++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: sequences one bus transfer at a time (register-to-register or
// immediate-to-register) by issuing one-hot output/input enables to the
// register file. It runs a drive phase, then a latch phase, then acknowledges.
// Optional feature macro: XFER_IMM_EN. When it is defined, immediate transfers
// are supported and this block drives the bus. When it is undefined, the bus is
// always high-Z from here and use_imm=1 requests are rejected with err.
module bus_xfer_ctrl #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [SEL_W-1:0]      src,
    input  logic [SEL_W-1:0]      dst,
    input  logic                  use_imm,
    input  logic [WIDTH-1:0]      imm,
    inout  logic [WIDTH-1:0]      bus,
    output logic [2**SEL_W-1:0]   out_en,
    output logic [2**SEL_W-1:0]   in_en,
    output logic                  busy,
    output logic                  ack,
    output logic                  err,
    output logic [WIDTH-1:0]      xfer_data
);

    localparam int unsigned NREG = 2**SEL_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_LATCH,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   src_q, src_d;
    logic [SEL_W-1:0]   dst_q, dst_d;
    logic               use_imm_q, use_imm_d;
    logic [NREG-1:0]    out_en_q, out_en_d;
    logic [NREG-1:0]    in_en_q, in_en_d;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   xfer_data_q, xfer_data_d;
    logic               legal;
    logic               phase_active;

`ifdef XFER_IMM_EN
    logic [WIDTH-1:0]   imm_q, imm_d;
    logic               drv_q, drv_d;

    assign legal = 1'b1;
    assign bus   = drv_q ? imm_q : 'z;
`else
    logic               unused_imm;

    assign legal      = ~use_imm;
    assign bus        = 'z;
    assign unused_imm = ^imm;
`endif

    // Next-state logic; every output is pre-computed from the next state so it is registered
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        use_imm_d   = use_imm_q;
`ifdef XFER_IMM_EN
        imm_d       = imm_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (req) begin
                    if (legal) begin
                        state_d   = S_DRIVE;
                        src_d     = src;
                        dst_d     = dst;
                        use_imm_d = use_imm;
`ifdef XFER_IMM_EN
                        imm_d     = imm;
`endif
                    end else begin
                        state_d = S_ERR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRIVE: state_d = S_LATCH;
            S_LATCH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // The source is driven from DRIVE through LATCH, so the bus is stable a full
        // cycle before in_en rises and stays held across the capture edge.
        phase_active = (state_d == S_DRIVE) || (state_d == S_LATCH);

        out_en_d = '0;
        if (phase_active && !use_imm_d) begin
            out_en_d = NREG'(1) << src_d;
        end

        in_en_d = '0;
        if (state_d == S_LATCH) begin
            in_en_d = NREG'(1) << dst_d;
        end

`ifdef XFER_IMM_EN
        drv_d = phase_active && use_imm_d;
`endif
        busy_d = phase_active;
        ack_d  = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);

        // The bus value is captured on the edge that closes LATCH, which is the same
        // edge where the destination register captures it.
        xfer_data_d = xfer_data_q;
        if (state_q == S_LATCH) begin
            xfer_data_d = bus;
        end
    end

    // State, latched request fields and registered outputs; reset clears them at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            use_imm_q   <= 1'b0;
            out_en_q    <= '0;
            in_en_q     <= '0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            xfer_data_q <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            use_imm_q   <= use_imm_d;
            out_en_q    <= out_en_d;
            in_en_q     <= in_en_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            xfer_data_q <= xfer_data_d;
        end
    end

`ifdef XFER_IMM_EN
    // Immediate value and bus drive enable; reset releases the bus immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imm_q <= '0;
            drv_q <= 1'b0;
        end else begin
            imm_q <= imm_d;
            drv_q <= drv_d;
        end
    end
`endif

    assign out_en    = out_en_q;
    assign in_en     = in_en_q;
    assign busy      = busy_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign xfer_data = xfer_data_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl. It contains a small register file that
// drives and captures the shared bus, plus a scoreboard of expected transfers.
module tb_bus_xfer_ctrl;

    logic        clk = 1'b0;
    logic        reset, req, use_imm;
    logic [2:0]  src, dst;
    logic [31:0] imm;
    wire  [31:0] bus;
    logic [7:0]  out_en, in_en;
    logic        busy, ack, err;
    logic [31:0] xfer_data;

    logic [31:0] regs [8];
    logic [31:0] shadow [8];
    logic        pl_en;
    logic [2:0]  pl_idx;
    logic [31:0] pl_val;
    logic        tb_drv;
    logic [31:0] tb_val;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [2:0]  dst;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    bus_xfer_ctrl #(.SEL_W(3), .WIDTH(32)) dut (
        .clk(clk), .reset(reset), .req(req), .src(src), .dst(dst),
        .use_imm(use_imm), .imm(imm), .bus(bus), .out_en(out_en),
        .in_en(in_en), .busy(busy), .ack(ack), .err(err), .xfer_data(xfer_data)
    );

    // Register file model: a register drives the bus while its out_en is high
    always_comb begin
        tb_drv = |out_en;
        tb_val = '0;
        for (int i = 0; i < 8; i++) begin
            if (out_en[i]) tb_val = regs[i];
        end
    end
    assign bus = tb_drv ? tb_val : 'z;

    // A register captures the bus on the clock edge while its in_en is high
    always @(posedge clk) begin
        if (pl_en) regs[pl_idx] <= pl_val;
        for (int i = 0; i < 8; i++) begin
            if (in_en[i]) regs[i] <= bus;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] d, input logic [31:0] v);
        exp_t e;
        e.dst = d;
        e.val = v;
        sb.push_back(e);
        shadow[d] = v;
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        chk({tag, "_sb_avail"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_xfer_data"}, xfer_data, e.val);
            chk({tag, "_dst_reg"}, regs[e.dst], e.val);
        end
    endtask

    task automatic drive_req(input logic [2:0] s, input logic [2:0] d,
                             input logic ui, input logic [31:0] im);
        src     = s;
        dst     = d;
        use_imm = ui;
        imm     = im;
        req     = 1'b1;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; use_imm = 1'b0; src = '0; dst = '0; imm = '0;
        pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_out_en", 32'(out_en), 32'h0);
        chk("rst_in_en", 32'(in_en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_xfer_data", xfer_data, 32'h0);
        cyc();
        reset = 1'b1;

        // Preload the register file with known contents
        for (int i = 0; i < 8; i++) begin
            shadow[i] = 32'hA000_0000 + 32'(i) * 32'h0101_0101;
        end
        shadow[2] = 32'h1234_5678;
        shadow[3] = 32'hCAFE_0003;
        for (int i = 0; i < 8; i++) begin
            pl_en = 1'b1; pl_idx = 3'(i); pl_val = shadow[i];
            cyc();
        end
        pl_en = 1'b0;
        cyc();

        // Register to register: 2 -> 5
        drive_req(3'd2, 3'd5, 1'b0, 32'h0);
        push(3'd5, shadow[2]);
        cyc();
        req = 1'b0;
        chk("r2r_c1_out_en", 32'(out_en), 32'h04);
        chk("r2r_c1_in_en", 32'(in_en), 32'h00);
        chk("r2r_c1_busy", 32'(busy), 32'h1);
        cyc();
        chk("r2r_c2_out_en", 32'(out_en), 32'h04);
        chk("r2r_c2_in_en", 32'(in_en), 32'h20);
        cyc();
        chk("r2r_c3_ack", 32'(ack), 32'h1);
        chk("r2r_c3_busy", 32'(busy), 32'h0);
        chk("r2r_c3_out_en", 32'(out_en), 32'h00);
        pop_chk("r2r");
        cyc();
        chk("r2r_c4_ack", 32'(ack), 32'h0);

        // Immediate to register: imm -> 7
        drive_req(3'd0, 3'd7, 1'b1, 32'hDEAD_BEEF);
`ifdef XFER_IMM_EN
        push(3'd7, 32'hDEAD_BEEF);
        cyc();
        req = 1'b0;
        chk("imm_c1_bus", bus, 32'hDEAD_BEEF);
        chk("imm_c1_out_en", 32'(out_en), 32'h00);
        cyc();
        chk("imm_c2_bus", bus, 32'hDEAD_BEEF);
        chk("imm_c2_in_en", 32'(in_en), 32'h80);
        cyc();
        chk("imm_c3_ack", 32'(ack), 32'h1);
        pop_chk("imm");
`else
        cyc();
        req = 1'b0;
        chk("imm_err_c1", 32'(err), 32'h1);
        chk("imm_err_out_en", 32'(out_en), 32'h00);
        chk("imm_err_in_en", 32'(in_en), 32'h00);
        chk("imm_err_busy", 32'(busy), 32'h0);
        cyc();
        chk("imm_err_c2", 32'(err), 32'h0);
        chk("imm_err_c2_ack", 32'(ack), 32'h0);
        chk("imm_err_r7", regs[7], shadow[7]);
`endif
        cyc();

        // Back-to-back with req held: 3 -> 1, then 1 -> 4
        drive_req(3'd3, 3'd1, 1'b0, 32'h0);
        push(3'd1, shadow[3]);
        cyc();
        chk("b2b_c1_out_en", 32'(out_en), 32'h08);
        src = 3'd1;
        dst = 3'd4;
        push(3'd4, shadow[1]);
        cyc();
        chk("b2b_c2_in_en", 32'(in_en), 32'h02);
        cyc();
        chk("b2b_c3_ack", 32'(ack), 32'h1);
        pop_chk("b2b_first");
        cyc();
        req = 1'b0;
        chk("b2b_c4_ack", 32'(ack), 32'h0);
        chk("b2b_c4_out_en", 32'(out_en), 32'h02);
        cyc();
        chk("b2b_c5_in_en", 32'(in_en), 32'h10);
        cyc();
        chk("b2b_c6_ack", 32'(ack), 32'h1);
        pop_chk("b2b_second");
        chk("b2b_r4_orig_r3", regs[4], 32'hCAFE_0003);

        // Request pulsed while busy is ignored: 2 -> 0, stray 6 -> 7
        drive_req(3'd2, 3'd0, 1'b0, 32'h0);
        push(3'd0, shadow[2]);
        cyc();
        req = 1'b0;
        cyc();
        drive_req(3'd6, 3'd7, 1'b0, 32'h0);
        chk("ign_c2_out_en", 32'(out_en), 32'h04);
        chk("ign_c2_in_en", 32'(in_en), 32'h01);
        cyc();
        req = 1'b0;
        chk("ign_c3_ack", 32'(ack), 32'h1);
        pop_chk("ign");
        cyc();
        chk("ign_c4_ack", 32'(ack), 32'h0);
        chk("ign_c4_busy", 32'(busy), 32'h0);
        chk("ign_r7", regs[7], shadow[7]);

        // Reset during LATCH: 0 -> 3 must not be written
        drive_req(3'd0, 3'd3, 1'b0, 32'h0);
        cyc();
        req = 1'b0;
        cyc();
        chk("rstl_c2_in_en", 32'(in_en), 32'h08);
        #1 reset = 1'b0;
        #1;
        chk("rstl_out_en", 32'(out_en), 32'h00);
        chk("rstl_in_en", 32'(in_en), 32'h00);
        chk("rstl_busy", 32'(busy), 32'h0);
        cyc();
        chk("rstl_ack", 32'(ack), 32'h0);
        chk("rstl_r3", regs[3], shadow[3]);
        chk("rstl_xfer_data", xfer_data, 32'h0);
        reset = 1'b1;

        // Self transfer 6 -> 6, requested right after reset release
        drive_req(3'd6, 3'd6, 1'b0, 32'h0);
        push(3'd6, shadow[6]);
        cyc();
        req = 1'b0;
        chk("self_c1_out_en", 32'(out_en), 32'h40);
        chk("self_c1_onehot", 32'($countones(out_en)), 32'd1);
        cyc();
        chk("self_c2_onehot", 32'($countones(out_en)), 32'd1);
        chk("self_c2_in_en", 32'(in_en), 32'h40);
        cyc();
        chk("self_c3_ack", 32'(ack), 32'h1);
        pop_chk("self");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
